csi_rx_pkt_parser: RTL and testbench
====================================

// Module: csi_rx_pkt_parser
// PURPOSE
//  Lane-count-generic MIPI CSI-2 packet parser; successor of the fixed 2-lane handler.
//  Sits between the word aligner and the ISP/unpacker.
//  Assembles the 32-bit header from 1/2/4-byte words, checks ECC/type/VC and tracks frame/line state.
//  Streams long-packet payload with a per-byte keep mask and a last flag; keeps saturating error counters.
// PARAMETERS
//  LANES    2        lanes = bytes per word; legal values 1, 2, 4
//  MAX_LEN  8192     largest accepted word count (WC), in bytes
//  VC_MASK  4'b0001  bit i set = virtual channel i accepted
//  CNT_W    8        width of the saturating error counters
// PORTS
//  clock          in   1          parser clock
//  reset          in   1          reset, asynchronous, active-high
//  enable         in   1          1 = advance; 0 = all state/regs hold
//  data           in   8*LANES    aligned word; [7:0] = lane 0 = earliest byte
//  data_valid     in   1          data qualifier from aligner
//  sync_wait      out  1          to byte/word aligner wait_for_sync
//  packet_done    out  1          to word aligner packet_done
//  payload_data   out  8*LANES    payload bytes; 0 when payload_valid=0
//  payload_keep   out  LANES      byte-valid mask of payload_data
//  payload_valid  out  1          payload word present
//  payload_last   out  1          final payload word of the packet
//  payload_vc     out  2          VC of current packet
//  payload_dt     out  6          data type of current packet
//  in_frame       out  1          FS seen, FE not yet (accepted VCs)
//  in_line        out  1          inside an accepted video long packet
//  frame_num      out  16         WC field of last accepted FS
//  ecc_err_cnt    out  CNT_W      headers with ECC mismatch
//  hdr_err_cnt    out  CNT_W      ECC-good headers: bad type, or WC>MAX_LEN
//  err_pulse      out  1          1-cycle pulse on any counted error
// BEHAVIOUR
//  Reset: state IDLE. All outputs 0 except sync_wait=1. Counters, frame_num, in_frame, in_line = 0.
//  Header bytes: DI (VC=[7:6], DT=[5:0]), WC_lo, WC_hi, ECC. HDR_WORDS = 4/LANES.
//  Expected ECC comes from csi_rx_hdr_ecc on {WC_hi,WC_lo,DI}. Mismatch = ECC error; no correction.
//  Allowed DT: 00-03, 10-12, 1E, 24, 28-2D. Long = DT>0x0F.
//  Accepted = ECC ok, DT allowed, WC<=MAX_LEN for long packets, VC_MASK[VC]=1.
//  Rejected VC: not counted, no flag change.
//  FSM; only data_valid cycles advance the IDLE/HDR/PAYLOAD states:
//   IDLE: sync_wait=1; valid word = header word 0 -> HDR (LANES<4); LANES=4 decides this cycle.
//   HDR: collect remaining words; decide in the cycle the last header word arrives.
//        Long & accepted & WC>0 -> PAYLOAD; else -> DONE.
//   PAYLOAD: payload_valid=data_valid; bytes_left starts at WC, minus LANES per valid word.
//        keep = bytes_left>=LANES ? all-1 : (1<<bytes_left)-1.
//        Word with bytes_left<=LANES: payload_last=1 -> DONE.
//        Footer CRC is not consumed; the aligner resync discards it.
//   DONE: packet_done=1 for 1 cycle -> STOP.   STOP: 1 idle cycle -> IDLE.
//  Payload latency: payload word is a registered copy, 1 cycle after its data_valid cycle.
//  Decision-cycle side effects, only on an accepted header:
//   FS (DT=00): in_frame<=1, frame_num<=WC.   FE (DT=01): in_frame<=0.
//   Video long packet (DT>=0x18): in_line<=1; in_line<=0 on the DONE cycle.
//  Counters saturate at all-1, no wrap. ECC error -> ecc_err_cnt only. err_pulse at the decision cycle.
//  data_valid low mid-packet: hold state and bytes_left; no payload output.
//  Reset mid-packet: immediate return to reset values; no packet_done emitted.
// TESTING
//  LANES=2, FS VC0, WC=0x0005 -> in_frame=1, frame_num=5, packet_done 1 cyc, no payload.
//  LANES=4, RAW10 DT=2B, WC=10 -> 3 payload words, keep 1111,1111,0011; last on 3rd; in_line 1 then 0.
//  LANES=1, header ECC bit flipped -> ecc_err_cnt=1, err_pulse, no payload, in_frame unchanged.
//  VC_MASK=0001, FS on VC2 -> no in_frame change, no counter change, packet_done still issued.
//  DT=0x3F with good ECC, 300 times, CNT_W=8 -> hdr_err_cnt saturates at 255.
//  WC=8194 long packet -> hdr_err_cnt+1, DONE; reset mid-payload -> all outputs at reset values.

Source files
------------

// File: rtl/csi_rx_pkt_parser.sv
// CSI-2 packet parser: assembles the 4-byte header from LANES-byte words, checks ECC/type/VC,
// tracks frame/line state and streams long-packet payload with a byte keep mask.
module csi_rx_pkt_parser #(
  parameter int         LANES   = 2,
  parameter int         MAX_LEN = 8192,
  parameter logic [3:0] VC_MASK = 4'b0001,
  parameter int         CNT_W   = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [8*LANES-1:0]   data,
  input  logic                 data_valid,
  output logic                 sync_wait,
  output logic                 packet_done,
  output logic [8*LANES-1:0]   payload_data,
  output logic [LANES-1:0]     payload_keep,
  output logic                 payload_valid,
  output logic                 payload_last,
  output logic [1:0]           payload_vc,
  output logic [5:0]           payload_dt,
  output logic                 in_frame,
  output logic                 in_line,
  output logic [15:0]          frame_num,
  output logic [CNT_W-1:0]     ecc_err_cnt,
  output logic [CNT_W-1:0]     hdr_err_cnt,
  output logic                 err_pulse,
  output logic [2:0]           dbg_state
);

  localparam int W         = 8 * LANES;
  localparam int HDR_WORDS = 4 / LANES;
  localparam logic ONE_WORD = (HDR_WORDS == 1);
  // Bit n set = data type n is a legal CSI-2 type for this parser.
  localparam logic [63:0] DT_OK = 64'h0000_3F10_4007_000F;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HDR     = 3'd1,
    S_PAYLOAD = 3'd2,
    S_DONE    = 3'd3,
    S_STOP    = 3'd4
  } state_t;

  // Handshake: a word on data is consumed only in a cycle with enable=1 and data_valid=1;
  // there is no backpressure, payload_valid marks each emitted word for exactly one enabled cycle.
  state_t             state_q;
  logic [1:0]         widx_q;
  logic [31:0]        hdr_buf_q;
  logic [15:0]        bytes_left_q;
  logic               sync_wait_q;
  logic               packet_done_q;
  logic [W-1:0]       payload_data_q;
  logic [LANES-1:0]   payload_keep_q;
  logic               payload_valid_q;
  logic               payload_last_q;
  logic [1:0]         payload_vc_q;
  logic [5:0]         payload_dt_q;
  logic               in_frame_q;
  logic               in_line_q;
  logic [15:0]        frame_num_q;
  logic [CNT_W-1:0]   ecc_err_cnt_q;
  logic [CNT_W-1:0]   hdr_err_cnt_q;
  logic               err_pulse_q;

  function automatic logic [5:0] ecc_calc(input logic [23:0] d);
    logic [5:0] p;
    p[0] = ^{d[0], d[1], d[2], d[4], d[5], d[7], d[10], d[11], d[13], d[16], d[20], d[21], d[22], d[23]};
    p[1] = ^{d[0], d[1], d[3], d[4], d[6], d[8], d[10], d[12], d[14], d[17], d[20], d[21], d[22], d[23]};
    p[2] = ^{d[0], d[2], d[3], d[5], d[6], d[9], d[11], d[12], d[15], d[18], d[20], d[21], d[22]};
    p[3] = ^{d[1], d[2], d[3], d[7], d[8], d[9], d[13], d[14], d[15], d[19], d[20], d[21], d[23]};
    p[4] = ^{d[4], d[5], d[6], d[7], d[8], d[9], d[16], d[17], d[18], d[19], d[20], d[22], d[23]};
    p[5] = ^{d[10], d[11], d[12], d[13], d[14], d[15], d[16], d[17], d[18], d[19], d[21], d[22], d[23]};
    return p;
  endfunction

  logic [31:0]      data_ext;
  logic [5:0]       shamt;
  logic [31:0]      hdr_full;
  logic [5:0]       dt;
  logic [1:0]       vc;
  logic [15:0]      wc;
  logic             last_hdr_word;
  logic             ecc_ok;
  logic             long_pkt;
  logic             wc_ok;
  logic             accepted;
  logic             ecc_err;
  logic             hdr_err;
  logic             to_payload;
  logic [LANES-1:0] keep_nx;
  logic             final_word;

  // The header is the buffered words plus the word arriving now, so the decision needs no extra cycle.
  always_comb begin
    data_ext      = 32'(data);
    shamt         = 6'(widx_q) * 6'(W);
    hdr_full      = ((state_q == S_IDLE) ? 32'd0 : hdr_buf_q) | (data_ext << shamt);
    vc            = hdr_full[7:6];
    dt            = hdr_full[5:0];
    wc            = hdr_full[23:8];
    last_hdr_word = (state_q == S_IDLE) ? ONE_WORD : (widx_q == 2'(HDR_WORDS - 1));
    ecc_ok        = (hdr_full[31:24] == {2'b00, ecc_calc(hdr_full[23:0])});
    long_pkt      = (dt > 6'h0F);
    wc_ok         = !long_pkt || (32'(wc) <= 32'(MAX_LEN));
    accepted      = ecc_ok && VC_MASK[vc] && DT_OK[dt] && wc_ok;
    ecc_err       = !ecc_ok;
    hdr_err       = ecc_ok && VC_MASK[vc] && !(DT_OK[dt] && wc_ok);
    to_payload    = accepted && long_pkt && (wc != 16'd0);
    final_word    = (bytes_left_q <= 16'(LANES));
    keep_nx       = '0;
    for (int i = 0; i < LANES; i++) begin
      keep_nx[i] = (bytes_left_q > 16'(i));
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q         <= S_IDLE;
      widx_q          <= 2'd0;
      hdr_buf_q       <= 32'd0;
      bytes_left_q    <= 16'd0;
      sync_wait_q     <= 1'b1;
      packet_done_q   <= 1'b0;
      payload_data_q  <= '0;
      payload_keep_q  <= '0;
      payload_valid_q <= 1'b0;
      payload_last_q  <= 1'b0;
      payload_vc_q    <= 2'd0;
      payload_dt_q    <= 6'd0;
      in_frame_q      <= 1'b0;
      in_line_q       <= 1'b0;
      frame_num_q     <= 16'd0;
      ecc_err_cnt_q   <= '0;
      hdr_err_cnt_q   <= '0;
      err_pulse_q     <= 1'b0;
    end else if (enable) begin
      packet_done_q   <= 1'b0;
      err_pulse_q     <= 1'b0;
      payload_valid_q <= 1'b0;
      payload_data_q  <= '0;
      payload_keep_q  <= '0;
      payload_last_q  <= 1'b0;
      case (state_q)
        S_IDLE, S_HDR: begin
          if (data_valid) begin
            sync_wait_q <= 1'b0;
            if (last_hdr_word) begin
              widx_q       <= 2'd0;
              payload_vc_q <= vc;
              payload_dt_q <= dt;
              err_pulse_q  <= ecc_err || hdr_err;
              if (ecc_err && (ecc_err_cnt_q != '1)) ecc_err_cnt_q <= ecc_err_cnt_q + 1'b1;
              if (hdr_err && (hdr_err_cnt_q != '1)) hdr_err_cnt_q <= hdr_err_cnt_q + 1'b1;
              if (accepted) begin
                if (dt == 6'h00) begin
                  in_frame_q  <= 1'b1;
                  frame_num_q <= wc;
                end
                if (dt == 6'h01) in_frame_q <= 1'b0;
                if (dt >= 6'h18) in_line_q <= 1'b1;
              end
              if (to_payload) begin
                state_q      <= S_PAYLOAD;
                bytes_left_q <= wc;
              end else begin
                state_q       <= S_DONE;
                packet_done_q <= 1'b1;
              end
            end else begin
              hdr_buf_q <= hdr_full;
              widx_q    <= widx_q + 2'd1;
              state_q   <= S_HDR;
            end
          end
        end
        S_PAYLOAD: begin
          if (data_valid) begin
            payload_valid_q <= 1'b1;
            payload_data_q  <= data;
            payload_keep_q  <= keep_nx;
            payload_last_q  <= final_word;
            bytes_left_q    <= bytes_left_q - 16'(LANES);
            if (final_word) begin
              state_q       <= S_DONE;
              packet_done_q <= 1'b1;
            end
          end
        end
        S_DONE: begin
          in_line_q <= 1'b0;
          state_q   <= S_STOP;
        end
        S_STOP: begin
          state_q     <= S_IDLE;
          sync_wait_q <= 1'b1;
        end
        default: begin
          state_q     <= S_IDLE;
          sync_wait_q <= 1'b1;
        end
      endcase
    end
  end

  assign sync_wait     = sync_wait_q;
  assign packet_done   = packet_done_q;
  assign payload_data  = payload_data_q;
  assign payload_keep  = payload_keep_q;
  assign payload_valid = payload_valid_q;
  assign payload_last  = payload_last_q;
  assign payload_vc    = payload_vc_q;
  assign payload_dt    = payload_dt_q;
  assign in_frame      = in_frame_q;
  assign in_line       = in_line_q;
  assign frame_num     = frame_num_q;
  assign ecc_err_cnt   = ecc_err_cnt_q;
  assign hdr_err_cnt   = hdr_err_cnt_q;
  assign err_pulse     = err_pulse_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_csi_rx_pkt_parser.sv
// Bench for csi_rx_pkt_parser: 1-, 2- and 4-lane instances driven with directed and random
// packets, compared against a byte-level packet model and a scoreboard of payload words.
module tb_csi_rx_pkt_parser;

  localparam int         MAX_LEN = 8192;
  localparam logic [3:0] VC_MASK = 4'b0001;
  // Per-data-bit ECC syndrome contributions (bit n of the 24-bit header -> 6-bit code).
  localparam logic [5:0] ECC_CODE [24] = '{
    6'h07, 6'h0B, 6'h0D, 6'h0E, 6'h13, 6'h15, 6'h16, 6'h19, 6'h1A, 6'h1C, 6'h23, 6'h25,
    6'h26, 6'h29, 6'h2A, 6'h2C, 6'h31, 6'h32, 6'h34, 6'h38, 6'h1F, 6'h2F, 6'h37, 6'h3B};
  localparam logic [5:0] DT_PICK [11] = '{
    6'h00, 6'h01, 6'h02, 6'h03, 6'h10, 6'h12, 6'h1E, 6'h24, 6'h2A, 6'h2B, 6'h2D};

  // clock / reset
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic        en   [3];
  logic [31:0] din  [3];
  logic        dv   [3];
  logic        o_sync [3], o_done [3], o_pv [3], o_pl [3], o_inf [3], o_inl [3], o_ep [3];
  logic [1:0]  o_vc  [3];
  logic [5:0]  o_dt  [3];
  logic [15:0] o_fn  [3];
  logic [7:0]  o_ecc [3];
  logic [7:0]  o_hdr [3];
  logic [2:0]  o_st  [3];
  logic [31:0] o_pd  [3];
  logic [3:0]  o_pk  [3];

  // index g: lanes = 1 << g
  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int L = 1 << g;
    logic [8*L-1:0] pd;
    logic [L-1:0]   pk;
    csi_rx_pkt_parser #(
      .LANES(L), .MAX_LEN(MAX_LEN), .VC_MASK(VC_MASK), .CNT_W(8)
    ) u_dut (
      .clock(clock), .reset(reset), .enable(en[g]),
      .data(din[g][8*L-1:0]), .data_valid(dv[g]),
      .sync_wait(o_sync[g]), .packet_done(o_done[g]),
      .payload_data(pd), .payload_keep(pk), .payload_valid(o_pv[g]), .payload_last(o_pl[g]),
      .payload_vc(o_vc[g]), .payload_dt(o_dt[g]),
      .in_frame(o_inf[g]), .in_line(o_inl[g]), .frame_num(o_fn[g]),
      .ecc_err_cnt(o_ecc[g]), .hdr_err_cnt(o_hdr[g]), .err_pulse(o_ep[g]),
      .dbg_state(o_st[g])
    );
    assign o_pd[g] = 32'(pd);
    assign o_pk[g] = 4'(pk);
  end

  // scoreboard
  logic [43:0] exp_q [$];
  logic [43:0] got_q [$];
  int          done_cnt [3];
  int          err_cnt  [3];
  int          zero_viol;
  int          checks;
  int          errors;
  string       cur;

  int          m_ecc [3];
  int          m_hdr [3];
  logic        m_inf [3];
  logic [15:0] m_fn  [3];

  always @(negedge clock) begin
    for (int g = 0; g < 3; g++) begin
      if (o_done[g]) done_cnt[g]++;
      if (o_ep[g]) err_cnt[g]++;
      if (o_pv[g]) got_q.push_back({o_inl[g], o_dt[g], o_pl[g], o_pk[g], o_pd[g]});
      else if (o_pd[g] != 32'd0 || o_pk[g] != 4'd0 || o_pl[g]) zero_viol++;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got=running expected=finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s %s: got=%0h expected=%0h", cur, tag, got, exp);
    end
  endtask

  function automatic logic [7:0] ref_ecc(input logic [23:0] d);
    logic [5:0] e = 6'd0;
    for (int i = 0; i < 24; i++) if (d[i]) e ^= ECC_CODE[i];
    return {2'b00, e};
  endfunction

  function automatic logic dt_allowed(input logic [5:0] t);
    return (t <= 6'h03) || (t >= 6'h10 && t <= 6'h12) || (t == 6'h1E) || (t == 6'h24) ||
           (t >= 6'h28 && t <= 6'h2D);
  endfunction

  function automatic logic [31:0] hdr_word(input logic [1:0] vc, input logic [5:0] dt,
                                           input logic [15:0] wc);
    logic [7:0] di = {vc, dt};
    return {ref_ecc({wc, di}), wc[15:8], wc[7:0], di};
  endfunction

  task automatic check_reset(input int g);
    check("rst sync_wait", o_sync[g], 1);
    check("rst packet_done", o_done[g], 0);
    check("rst payload_valid", o_pv[g], 0);
    check("rst payload_data", o_pd[g], 0);
    check("rst payload_keep", o_pk[g], 0);
    check("rst payload_last", o_pl[g], 0);
    check("rst payload_vc", o_vc[g], 0);
    check("rst payload_dt", o_dt[g], 0);
    check("rst in_frame", o_inf[g], 0);
    check("rst in_line", o_inl[g], 0);
    check("rst frame_num", o_fn[g], 0);
    check("rst ecc_err_cnt", o_ecc[g], 0);
    check("rst hdr_err_cnt", o_hdr[g], 0);
    check("rst err_pulse", o_ep[g], 0);
  endtask

  task automatic model_reset();
    for (int g = 0; g < 3; g++) begin
      m_ecc[g] = 0; m_hdr[g] = 0; m_inf[g] = 1'b0; m_fn[g] = 16'd0;
    end
  endtask

  // driver: one packet into instance g, then model update and checks
  task automatic run_pkt(input int g, input logic [1:0] vc, input logic [5:0] dt,
                         input logic [15:0] wc, input int flip);
    logic [7:0]  bytes [$];
    logic [31:0] hw, w;
    logic [3:0]  k;
    logic        ecc_ok, long_pkt, dt_ok, wc_ok, vc_ok, acc, exp_err;
    int          L, nwords, rem, d0, e0, n;
    L  = 1 << g;
    hw = hdr_word(vc, dt, wc);
    ecc_ok = (flip < 0);
    if (!ecc_ok) hw[24 + flip] = ~hw[24 + flip];
    long_pkt = (dt > 6'h0F);
    dt_ok    = dt_allowed(dt);
    wc_ok    = !long_pkt || (int'(wc) <= MAX_LEN);
    vc_ok    = VC_MASK[vc];
    acc      = ecc_ok && dt_ok && wc_ok && vc_ok;
    bytes    = {hw[7:0], hw[15:8], hw[23:16], hw[31:24]};
    exp_q.delete();
    if (acc && long_pkt && wc != 16'd0) begin
      nwords = (int'(wc) + L - 1) / L;
      for (int i = 0; i < nwords * L; i++) bytes.push_back(8'($urandom));
      for (int i = 0; i < nwords; i++) begin
        rem = int'(wc) - i * L;
        w = 32'd0;
        for (int b = 0; b < L; b++) w[8*b +: 8] = bytes[4 + i*L + b];
        k = (rem >= L) ? 4'((1 << L) - 1) : 4'((1 << rem) - 1);
        exp_q.push_back({(dt >= 6'h18), dt, (rem <= L), k, w});
      end
    end
    exp_err = 1'b0;
    if (!ecc_ok) begin
      exp_err = 1'b1;
      if (m_ecc[g] < 255) m_ecc[g]++;
    end else if (vc_ok) begin
      if (!dt_ok || !wc_ok) begin
        exp_err = 1'b1;
        if (m_hdr[g] < 255) m_hdr[g]++;
      end else if (dt == 6'h00) begin
        m_inf[g] = 1'b1; m_fn[g] = wc;
      end else if (dt == 6'h01) m_inf[g] = 1'b0;
    end

    got_q.delete();
    d0 = done_cnt[g];
    e0 = err_cnt[g];
    for (int i = 0; i < bytes.size(); i += L) begin
      repeat ($urandom_range(0, 2)) begin
        @(negedge clock);
        dv[g] = 1'b0; din[g] = $urandom;
      end
      @(negedge clock);
      w = 32'd0;
      for (int b = 0; b < L; b++) w[8*b +: 8] = bytes[i + b];
      din[g] = w; dv[g] = 1'b1;
    end
    @(negedge clock);
    dv[g] = 1'b0; din[g] = 32'd0;
    repeat (6) @(negedge clock);

    check("packet_done pulses", done_cnt[g] - d0, 1);
    check("err_pulse pulses", err_cnt[g] - e0, exp_err);
    check("in_frame", o_inf[g], m_inf[g]);
    check("frame_num", o_fn[g], m_fn[g]);
    check("ecc_err_cnt", o_ecc[g], m_ecc[g]);
    check("hdr_err_cnt", o_hdr[g], m_hdr[g]);
    check("in_line after", o_inl[g], 0);
    check("sync_wait after", o_sync[g], 1);
    check("payload words", got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check("payload {line,dt,last,keep,data}", got_q[i], exp_q[i]);
  endtask

  initial begin
    logic [1:0]  vc;
    logic [5:0]  dt;
    logic [15:0] wc;
    int          idx, flip, d0;
    checks = 0; errors = 0; zero_viol = 0;
    for (int g = 0; g < 3; g++) begin
      en[g] = 1'b1; dv[g] = 1'b0; din[g] = 32'd0; done_cnt[g] = 0; err_cnt[g] = 0;
    end
    model_reset();
    cur = "reset";
    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    for (int g = 0; g < 3; g++) check_reset(g);

    cur = "L2 FS wc5";       run_pkt(1, 2'd0, 6'h00, 16'd5, -1);
    cur = "L4 RAW10 wc10";   run_pkt(2, 2'd0, 6'h2B, 16'd10, -1);
    cur = "L1 FS wc3";       run_pkt(0, 2'd0, 6'h00, 16'd3, -1);
    cur = "L1 FE bad ecc";   run_pkt(0, 2'd0, 6'h01, 16'd0, 2);
    cur = "L2 FE vc2";       run_pkt(1, 2'd2, 6'h01, 16'd0, -1);
    cur = "L2 FS vc2";       run_pkt(1, 2'd2, 6'h00, 16'd9, -1);
    cur = "L2 wc8194";       run_pkt(1, 2'd0, 6'h2B, 16'd8194, -1);
    cur = "L4 wc8193";       run_pkt(2, 2'd0, 6'h2A, 16'd8193, -1);
    cur = "L4 wc8192";       run_pkt(2, 2'd0, 6'h2A, 16'd8192, -1);
    cur = "L1 RAW8 wc5";     run_pkt(0, 2'd0, 6'h2A, 16'd5, -1);
    cur = "L2 long wc0";     run_pkt(1, 2'd0, 6'h2B, 16'd0, -1);

    cur = "L4 dt3F sat";
    for (int i = 0; i < 300; i++) run_pkt(2, 2'd0, 6'h3F, 16'($urandom_range(0, 100)), -1);
    check("hdr_err_cnt saturated", o_hdr[2], 255);

    for (int g = 0; g < 3; g++) begin
      cur = $sformatf("random L%0d", 1 << g);
      for (int i = 0; i < 40; i++) begin
        vc  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
        idx = $urandom_range(0, 11);
        dt  = (idx == 11) ? 6'($urandom) : DT_PICK[idx];
        if (dt <= 6'h0F) wc = 16'($urandom);
        else if ($urandom_range(0, 9) == 0) wc = 16'($urandom_range(MAX_LEN + 1, 65535));
        else wc = 16'($urandom_range(0, 40));
        flip = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 7) : -1;
        run_pkt(g, vc, dt, wc, flip);
      end
    end

    cur = "L4 FS before reset";
    run_pkt(2, 2'd0, 6'h00, 16'h1234, -1);
    cur = "mid-payload reset";
    d0 = done_cnt[2];
    @(negedge clock);
    din[2] = hdr_word(2'd0, 6'h2B, 16'd40); dv[2] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      din[2] = $urandom; dv[2] = 1'b1;
    end
    @(negedge clock);
    dv[2] = 1'b0;
    reset = 1'b1;
    #1;
    model_reset();
    for (int g = 0; g < 3; g++) check_reset(g);
    @(negedge clock);
    reset = 1'b0;
    repeat (5) @(negedge clock);
    check("no packet_done after reset", done_cnt[2] - d0, 0);
    check_reset(2);
    cur = "L4 recovery";
    run_pkt(2, 2'd0, 6'h2B, 16'd7, -1);

    cur = "final";
    check("payload zero when not valid", zero_viol, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
